// File: rtl/goertzel_angle_gen.sv
// Goertzel angle generator: for each of NF frequency channels computes
// angle[n] = ((freq[n] >> 1) * coef) >> SH, saturating to all ones on overflow.
// Channels are processed one per cycle from inputs latched on start.
// Optional build macro: GOERTZEL_ANGLE_ROUND_EN (round-half-up instead of truncate).
module goertzel_angle_gen #(
  parameter int NF = 11,
  parameter int FW = 32,
  parameter int CW = 32,
  parameter int AW = 32,
  parameter int SH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             clear,
  input  logic [CW-1:0]    coef_i,
  input  logic [NF*FW-1:0] freq_i,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [NF*AW-1:0] angle_o
);

  localparam int IW = (NF > 1) ? $clog2(NF) : 1;
  localparam int PW = FW + CW;
  // One guard bit above the product so the rounding add cannot wrap and the
  // saturation slice is never empty even when AW+SH == FW+CW.
  localparam int EW = PW + 1;
  localparam int RW = EW - SH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      coef_q;
  logic [NF*FW-1:0]   freq_q;
  logic               valid_q;
  logic [NF*AW-1:0]   angle_q;

  logic               last;
  logic [FW-1:0]      f_sel;
  logic [FW-1:0]      k;
  logic [PW-1:0]      p;
  logic [EW-1:0]      ext;
  logic [RW-1:0]      shr;
  logic               sat;
  logic [AW-1:0]      angle;

  assign last = (idx == IW'(NF - 1));

  // Single shared multiplier: select the current channel from the latched word.
  assign f_sel = freq_q[int'(idx)*FW +: FW];
  assign k     = f_sel >> 1;
  assign p     = PW'(k) * PW'(coef_q);

`ifdef GOERTZEL_ANGLE_ROUND_EN
  assign ext = {1'b0, p} + (EW'(1) << (SH - 1));
`else
  assign ext = {1'b0, p};
`endif

  assign shr   = RW'(ext >> SH);
  assign sat   = |shr[RW-1:AW];
  assign angle = sat ? {AW{1'b1}} : shr[AW-1:0];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; clear overrides everything, start only honoured in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign valid   = valid_q;
  assign angle_o = angle_q;

  // Channel index and result-set qualifier.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx     <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      idx     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx     <= '0;
          valid_q <= 1'b0;
        end
        CALC: begin
          idx <= last ? '0 : idx + 1'b1;
          if (last) valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Input latches and per-channel result registers; results hold on clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_q  <= '0;
      freq_q  <= '0;
      angle_q <= '0;
    end else if (!clear) begin
      if (state == IDLE && start) begin
        coef_q <= coef_i;
        freq_q <= freq_i;
      end
      if (state == CALC) angle_q[int'(idx)*AW +: AW] <= angle;
    end
  end

endmodule
